// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block.
// Holds the FSM state enum, the 32-bit count type, the duty scale constant
// and the measurement payload published on the capture bus.
package pwm_capture_pkg;

  localparam int unsigned CNT_W      = 32;
  localparam int unsigned DUTY_W     = 7;
  localparam int unsigned PROD_W     = 39;
  localparam int unsigned DUTY_SCALE = 100;

  typedef logic [CNT_W-1:0]  count_t;
  typedef logic [DUTY_W-1:0] duty_t;
  typedef logic [PROD_W-1:0] prod_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  typedef struct packed {
    count_t period;
    count_t high_time;
    duty_t  duty_pct;
  } meas_t;

  // high_time scaled to percent units; 39 bits hold any 32-bit count * 100.
  function automatic prod_t scale_high(input count_t high);
    return PROD_W'(high) * PROD_W'(DUTY_SCALE);
  endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// Capture bus: PWM input plus the published measurement and status pulses.
// master: the capture block (samples pwm_in, drives results).
// slave:  the consumer (drives pwm_in, observes results).
interface pwm_capture_if;
  import pwm_capture_pkg::*;

  logic   pwm_in;
  count_t period;
  count_t high_time;
  duty_t  duty_pct;
  logic   meas_valid;
  logic   overrun;
  logic   timeout;

  modport master (
    input  pwm_in,
    output period, high_time, duty_pct, meas_valid, overrun, timeout
  );

  modport slave (
    output pwm_in,
    input  period, high_time, duty_pct, meas_valid, overrun, timeout
  );

endinterface

// File: rtl/pwm_duty_div.sv
// Sequential restoring divider producing the 7-bit duty quotient.
// Ports: clk, rst_n; start (load operands when idle); dividend (39 b),
// divisor (32 b); busy (load cycle through publish cycle); done (one-cycle
// pulse, quotient valid); quotient (7 b, floor(dividend/divisor)).
module pwm_duty_div
  import pwm_capture_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   start,
  input  prod_t  dividend,
  input  count_t divisor,
  output logic   busy,
  output logic   done,
  output duty_t  quotient
);

  localparam int unsigned STEP_W    = 4;
  localparam int unsigned LAST_BIT  = DUTY_W - 1;
  localparam int unsigned HOLD_STEP = DUTY_W + 1;

  prod_t              rem_q;
  prod_t              dsh_q;
  duty_t              quo_q;
  logic [STEP_W-1:0]  step_q;
  logic               busy_q;
  logic               done_q;
  logic               fits_c;
  prod_t              diff_c;

  // Trial subtraction of the aligned divisor from the partial remainder.
  always_comb begin
    fits_c = (rem_q >= dsh_q);
    diff_c = rem_q - dsh_q;
  end

  // Steps 0..6 resolve one quotient bit each, MSB first; busy is held two
  // further steps (done cycle + publish cycle) so a new capture can never
  // land before the previous result is out, giving a 10-cycle minimum period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      dsh_q  <= '0;
      quo_q  <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start && !busy_q) begin
      rem_q  <= dividend;
      dsh_q  <= PROD_W'(divisor) << LAST_BIT;
      quo_q  <= '0;
      step_q <= '0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      done_q <= 1'b0;
      if (step_q < STEP_W'(DUTY_W)) begin
        if (fits_c) begin
          rem_q <= diff_c;
        end
        quo_q  <= {quo_q[DUTY_W-2:0], fits_c};
        dsh_q  <= dsh_q >> 1;
        done_q <= (step_q == STEP_W'(LAST_BIT));
      end
      if (step_q == STEP_W'(HOLD_STEP)) begin
        busy_q <= 1'b0;
      end
      step_q <= step_q + STEP_W'(1);
    end else begin
      done_q <= 1'b0;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time / duty measurement with edge-loss timeout.
// Ports: clk, rst_n (async active-low); bus (master modport):
//   pwm_in in; period, high_time (32 b), duty_pct (7 b) measurement;
//   meas_valid pulse on update; overrun pulse on dropped capture;
//   timeout level while no rising edge within TIMEOUT_CYCLES.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = CLK_FREQ / 50
) (
  input  logic          clk,
  input  logic          rst_n,
  pwm_capture_if.master bus
);

  // Counters stop one short of the limit: the step that would reach it
  // goes to IDLE instead, so timeout shows exactly TIMEOUT_CYCLES after an edge.
  localparam count_t TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic   sync1_q, sync2_q, hist_q;
  logic   rise_c, fall_c, rise_next_c;

  state_e state_q, state_d;
  count_t cnt_period_q, cnt_period_d;
  count_t cnt_high_q, cnt_high_d;
  count_t idle_cnt_q, idle_cnt_d;
  logic   timeout_q, timeout_d;
  logic   complete_c;

  logic   div_start_c;
  logic   div_busy;
  logic   div_done;
  duty_t  div_quotient;

  count_t cap_period_q, cap_high_q;
  meas_t  meas_q;
  logic   meas_valid_q;
  logic   overrun_q;

  // Two-flop synchronizer plus history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= bus.pwm_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign rise_c      = sync2_q & ~hist_q;
  assign fall_c      = ~sync2_q & hist_q;
  // A rise one stage up the synchronizer is certain to be detected next
  // cycle; clearing on it lets the registered timeout drop in the detect cycle.
  assign rise_next_c = sync1_q & ~sync2_q;

  // State register and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_period_q <= '0;
      cnt_high_q   <= '0;
      idle_cnt_q   <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_period_q <= cnt_period_d;
      cnt_high_q   <= cnt_high_d;
      idle_cnt_q   <= idle_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next state, counter updates and completion detect.
  always_comb begin
    state_d      = state_q;
    cnt_period_d = cnt_period_q;
    cnt_high_d   = cnt_high_q;
    idle_cnt_d   = idle_cnt_q;
    timeout_d    = timeout_q;
    complete_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_period_d = '0;
        cnt_high_d   = '0;
        if (rise_c) begin
          state_d      = ST_HIGH;
          cnt_period_d = CNT_W'(1);
          cnt_high_d   = CNT_W'(1);
          idle_cnt_d   = '0;
        end else if (!timeout_q) begin
          // Silence counter used only until the first timeout after reset.
          if (idle_cnt_q == TIMEOUT_LAST) begin
            timeout_d  = 1'b1;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
          end
        end
      end

      ST_HIGH, ST_LOW: begin
        if (rise_c) begin
          // In HIGH cnt_high tracks cnt_period, so a missed fall yields
          // high_time == period with no special case.
          complete_c   = 1'b1;
          state_d      = ST_HIGH;
          cnt_period_d = CNT_W'(1);
          cnt_high_d   = CNT_W'(1);
        end else if (cnt_period_q == TIMEOUT_LAST) begin
          state_d      = ST_IDLE;
          cnt_period_d = '0;
          cnt_high_d   = '0;
          timeout_d    = 1'b1;
        end else begin
          cnt_period_d = cnt_period_q + CNT_W'(1);
          if (state_q == ST_HIGH) begin
            if (fall_c) begin
              state_d = ST_LOW;
            end else begin
              cnt_high_d = cnt_high_q + CNT_W'(1);
            end
          end
        end
      end

      default: begin
        state_d      = ST_IDLE;
        cnt_period_d = '0;
        cnt_high_d   = '0;
      end
    endcase

    if (rise_next_c) begin
      timeout_d = 1'b0;
    end
  end

  assign div_start_c = complete_c & ~div_busy;

  pwm_duty_div u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start_c),
    .dividend (scale_high(cnt_high_q)),
    .divisor  (cnt_period_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  // Captured operands wait here until the divider result publishes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_period_q <= '0;
      cap_high_q   <= '0;
      meas_q       <= '0;
      meas_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (div_start_c) begin
        cap_period_q <= cnt_period_q;
        cap_high_q   <= cnt_high_q;
      end
      if (div_done) begin
        meas_q <= '{period: cap_period_q, high_time: cap_high_q, duty_pct: div_quotient};
      end
      meas_valid_q <= div_done;
      overrun_q    <= complete_c & div_busy;
    end
  end

  assign bus.period     = meas_q.period;
  assign bus.high_time  = meas_q.high_time;
  assign bus.duty_pct   = meas_q.duty_pct;
  assign bus.meas_valid = meas_valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: directed and random PWM trains
// compared against an edge-time reference model.
module tb_pwm_capture;

  localparam int unsigned CLK_FREQ = 250_000;
  localparam int unsigned T        = CLK_FREQ / 50;

  typedef struct {
    int unsigned       cyc;
    longint unsigned   period;
    longint unsigned   high;
    longint unsigned   duty;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned cyc = 0;
  int n_tests = 0;
  int n_fail  = 0;

  pwm_capture_if bus ();

  pwm_capture #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: times are rising/falling edge detect cycles.
  exp_t        exp_q[$];
  int unsigned ovr_q[$];
  int unsigned det_q[$];
  bit          m_have, m_fall_seen, m_started;
  int unsigned m_prev, m_fall, m_last_start;

  // Monitor state.
  bit          mon_en = 1'b0;
  bit          exp_mv, exp_ov, exp_to, prev_exp_to, prev_act_to;
  int unsigned last_evt;
  int          mv_seen = 0;
  int          ovr_seen = 0;

  task automatic check(input string tag, input longint unsigned act, input longint unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    ovr_q.delete();
    det_q.delete();
    m_have      = 1'b0;
    m_fall_seen = 1'b0;
    m_started   = 1'b0;
  endtask

  // A measurement completes when a rise follows the previous one within T;
  // it publishes 9 cycles later unless the previous accepted one began < 10 ago.
  task automatic model_rise(input int unsigned d);
    longint unsigned p, h;
    det_q.push_back(d);
    if (m_have && (d - m_prev) < T) begin
      p = 64'(d - m_prev);
      h = m_fall_seen ? 64'(m_fall - m_prev) : p;
      if (!m_started || (d - m_last_start) >= 10) begin
        exp_q.push_back('{d + 9, p, h, (h * 100) / p});
        m_started    = 1'b1;
        m_last_start = d;
      end else begin
        ovr_q.push_back(d + 1);
      end
    end
    m_have      = 1'b1;
    m_prev      = d;
    m_fall_seen = 1'b0;
  endtask

  // Input changes in cycle c are detected in cycle c+2 after synchronization.
  task automatic set_pwm(input logic v);
    if (v && !bus.pwm_in) begin
      model_rise(cyc + 2);
    end else if (!v && bus.pwm_in) begin
      m_fall      = cyc + 2;
      m_fall_seen = 1'b1;
    end
    bus.pwm_in = v;
  endtask

  task automatic pulse(input int unsigned hi, input int unsigned lo);
    set_pwm(1'b1);
    repeat (hi) tick();
    set_pwm(1'b0);
    repeat (lo) tick();
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_period"},  64'(bus.period),     64'd0);
    check({pfx, "_high"},    64'(bus.high_time),  64'd0);
    check({pfx, "_duty"},    64'(bus.duty_pct),   64'd0);
    check({pfx, "_valid"},   64'(bus.meas_valid), 64'd0);
    check({pfx, "_overrun"}, 64'(bus.overrun),    64'd0);
    check({pfx, "_timeout"}, 64'(bus.timeout),    64'd0);
  endtask

  task automatic release_reset();
    rst_n       = 1'b1;
    last_evt    = cyc;
    prev_exp_to = 1'b0;
    prev_act_to = 1'b0;
    model_clear();
    mon_en      = 1'b1;
  endtask

  // Per-cycle scoreboard: checks every expected or observed pulse and every
  // change of the expected or observed timeout level.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (det_q.size() != 0 && det_q[0] == cyc) begin
        last_evt = cyc;
        void'(det_q.pop_front());
      end
      exp_mv = (exp_q.size() != 0) && (exp_q[0].cyc == cyc);
      if (bus.meas_valid) mv_seen++;
      if (bus.meas_valid || exp_mv) begin
        check("meas_valid", 64'(bus.meas_valid), 64'(exp_mv));
        if (exp_mv) begin
          check("period",    64'(bus.period),    exp_q[0].period);
          check("high_time", 64'(bus.high_time), exp_q[0].high);
          check("duty_pct",  64'(bus.duty_pct),  exp_q[0].duty);
          void'(exp_q.pop_front());
        end
      end
      exp_ov = (ovr_q.size() != 0) && (ovr_q[0] == cyc);
      if (bus.overrun) ovr_seen++;
      if (bus.overrun || exp_ov) begin
        check("overrun", 64'(bus.overrun), 64'(exp_ov));
        if (exp_ov) void'(ovr_q.pop_front());
      end
      exp_to = (cyc - last_evt) >= T;
      if (exp_to != prev_exp_to || bus.timeout != prev_act_to) begin
        check("timeout", 64'(bus.timeout), 64'(exp_to));
      end
      prev_exp_to = exp_to;
      prev_act_to = bus.timeout;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time %0t expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          k;
    int unsigned c;
    int          snap;

    rst_n      = 1'b0;
    bus.pwm_in = 1'b0;
    repeat (3) tick();
    check_zero("rst");
    release_reset();

    // Silence from reset: timeout after T cycles.
    repeat (T + 20) tick();
    check("to_after_reset", 64'(bus.timeout), 64'd1);

    // Nominal train: three rises, two measurements at 10 %.
    repeat (3) pulse(200, 1800);
    repeat (T) tick();
    check("hold_period", 64'(bus.period),    64'd2000);
    check("hold_high",   64'(bus.high_time), 64'd200);
    check("hold_duty",   64'(bus.duty_pct),  64'd10);
    check("hold_to",     64'(bus.timeout),   64'd1);

    // Minimum period: no overruns, 50 %.
    snap = ovr_seen;
    repeat (20) pulse(5, 5);
    check("p10_no_overrun", 64'(ovr_seen), 64'(snap));
    check("p10_duty", 64'(bus.duty_pct), 64'd50);

    // Too-short period: overruns must appear.
    snap = ovr_seen;
    repeat (12) pulse(4, 4);
    check("p8_overrun", 64'(ovr_seen > snap), 64'd1);

    // Near-full duty.
    repeat (6) pulse(100, 1);
    repeat (20) tick();
    check("p101_duty", 64'(bus.duty_pct), 64'd99);

    // Edge-to-valid latency, then pwm_in stuck high.
    pulse(100, 1);
    c = cyc;
    set_pwm(1'b1);
    k = 0;
    while (!bus.meas_valid && k < 30) begin
      tick();
      k++;
    end
    check("latency", 64'(cyc - c), 64'd11);
    repeat (T + 20) tick();
    check("stuck_to",   64'(bus.timeout),  64'd1);
    check("stuck_duty", 64'(bus.duty_pct), 64'd99);
    set_pwm(1'b0);
    repeat (10) tick();

    // Random trains including sub-minimum periods.
    repeat (60) pulse($urandom_range(1, 40), $urandom_range(1, 40));
    repeat (30) tick();

    // Asynchronous reset in the middle of a high phase.
    set_pwm(1'b1);
    repeat (5) tick();
    #2;
    rst_n      = 1'b0;
    bus.pwm_in = 1'b0;
    mon_en     = 1'b0;
    #1;
    check_zero("async_rst");
    repeat (3) tick();
    release_reset();
    snap = mv_seen;
    pulse(20, 20);
    check("first_rise_no_valid", 64'(mv_seen), 64'(snap));
    pulse(20, 20);
    repeat (5) tick();
    check("second_rise_valid", 64'(mv_seen), 64'(snap + 1));

    repeat (40) tick();
    check("exp_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
